// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings and default latencies.
package md_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_t;

  localparam int unsigned MD_MULT_CYCLES = 5;
  localparam int unsigned MD_DIV_CYCLES  = 10;

  function automatic logic is_arith_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational datapath for mult/multu/div/divu, producing {hi,lo} and a divide-by-zero flag.
module md_arith
  import md_pkg::*;
(
  input  logic [3:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_zero
);

  logic [63:0] a_sx, b_sx, a_zx, b_zx;
  logic        div_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;

  assign a_sx = {{32{a[31]}}, a};
  assign b_sx = {{32{b[31]}}, b};
  assign a_zx = {32'd0, a};
  assign b_zx = {32'd0, b};

  // Division runs on magnitudes so INT_MIN / -1 wraps to INT_MIN with zero remainder;
  // a zero divisor is replaced by 1 only to keep the divider defined, the result is discarded.
  assign div_signed = (md_op == MD_DIV);
  assign a_neg      = div_signed & a[31];
  assign b_neg      = div_signed & b[31];
  assign a_mag      = a_neg ? (32'd0 - a) : a;
  assign b_mag      = (b == 32'd0) ? 32'd1 : (b_neg ? (32'd0 - b) : b);
  assign q_mag      = a_mag / b_mag;
  assign r_mag      = a_mag % b_mag;
  assign quo        = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem        = a_neg ? (32'd0 - r_mag) : r_mag;

  always_comb begin
    result   = '0;
    div_zero = 1'b0;
    case (md_op)
      MD_MULT:  result = a_sx * b_sx;
      MD_MULTU: result = a_zx * b_zx;
      MD_DIV, MD_DIVU: begin
        result   = {rem, quo};
        div_zero = (b == 32'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit: owns HI/LO, runs arithmetic over a fixed latency, serves mfhi/mflo.
module mult_div_unit
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic        cancel,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        start,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             pend_wr_q, pend_wr_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic [63:0]      arith_res;
  logic             arith_div_zero;

  md_arith u_arith (
    .md_op    (md_op),
    .a        (a),
    .b        (b),
    .result   (arith_res),
    .div_zero (arith_div_zero)
  );

  assign start  = is_arith_op(md_op) & ~busy_q & ~cancel;
  assign busy   = busy_q;
  assign hi     = hi_q;
  assign lo     = lo_q;
  assign md_out = (md_op == MD_MFHI) ? hi_q : lo_q;

  always_comb begin
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    pend_wr_d = pend_wr_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (start) begin
      pend_hi_d = arith_res[63:32];
      pend_lo_d = arith_res[31:0];
      pend_wr_d = ~arith_div_zero;
      cnt_d     = is_div_op(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      busy_d    = 1'b1;
    end else if (busy_q) begin
      // In-flight operations ignore cancel and any newly issued MD op.
      if (cnt_q > CNT_W'(1)) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        cnt_d  = '0;
        busy_d = 1'b0;
        if (pend_wr_q) begin
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
        end
      end
    end else if (!cancel) begin
      if (md_op == MD_MTHI) hi_d = a;
      if (md_op == MD_MTLO) lo_d = a;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      pend_wr_q <= 1'b0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      pend_wr_q <= pend_wr_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit with hand-computed HI/LO expectations.
module tb_mult_div_unit;
  import md_pkg::*;

  logic        clk;
  logic        reset;
  logic [3:0]  md_op;
  logic        cancel;
  logic [31:0] a, b;
  logic        busy, start;
  logic [31:0] hi, lo, md_out;

  int checks = 0;
  int errors = 0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .md_op  (md_op),
    .cancel (cancel),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .start  (start),
    .hi     (hi),
    .lo     (lo),
    .md_out (md_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Counts negedge samples with busy high; bounded so a stuck busy ends as a failed count.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
    md_op = op;
    a     = av;
    b     = bv;
    #1;
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] av,
                        input logic [31:0] bv, input int n_exp,
                        input logic [31:0] hi_exp, input logic [31:0] lo_exp);
    int n;
    issue(op, av, bv);
    check({tag, " start"}, 32'(start), 32'd1);
    @(negedge clk);
    md_op = MD_NONE;
    wait_idle(n);
    check({tag, " cycles"}, 32'(n), 32'(n_exp));
    check({tag, " hi"}, hi, hi_exp);
    check({tag, " lo"}, lo, lo_exp);
  endtask

  initial begin
    int n;
    reset  = 1'b1;
    cancel = 1'b0;
    md_op  = MD_NONE;
    a      = '0;
    b      = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    check("reset busy", 32'(busy), 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    check("reset md_out", md_out, 32'd0);

    run_op("mult -2*3", MD_MULT, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div -7/2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    issue(MD_MTHI, 32'h11, 32'd0);
    @(negedge clk);
    issue(MD_MTLO, 32'h22, 32'd0);
    @(negedge clk);
    run_op("div by zero", MD_DIV, 32'd5, 32'd0, 10, 32'h11, 32'h22);

    run_op("divu 100/7", MD_DIVU, 32'd100, 32'd7, 10, 32'd2, 32'd14);
    run_op("div overflow", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
    run_op("div 7/-2", MD_DIV, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD);

    issue(MD_MTLO, 32'h1234, 32'd0);
    @(negedge clk);
    issue(MD_MFLO, 32'd0, 32'd0);
    check("mflo after mtlo", md_out, 32'h1234);
    @(negedge clk);
    issue(MD_MTHI, 32'hABCD, 32'd0);
    @(negedge clk);
    issue(MD_MFHI, 32'd0, 32'd0);
    check("mfhi after mthi", md_out, 32'hABCD);
    @(negedge clk);

    // MULT in flight; a DIV and an MTHI issued during it must be ignored.
    issue(MD_MULT, 32'd3, 32'd4);
    check("mult 3*4 start", 32'(start), 32'd1);
    @(negedge clk);
    issue(MD_DIV, 32'd100, 32'd7);
    check("div while busy start", 32'(start), 32'd0);
    @(negedge clk);
    issue(MD_MTHI, 32'hDEAD, 32'd0);
    @(negedge clk);
    md_op = MD_NONE;
    wait_idle(n);
    check("mult 3*4 cycles", 32'(n + 2), 32'd5);
    check("mult 3*4 hi", hi, 32'd0);
    check("mult 3*4 lo", lo, 32'd12);

    cancel = 1'b1;
    issue(MD_MULT, 32'd5, 32'd5);
    check("cancel start", 32'(start), 32'd0);
    @(negedge clk);
    check("cancel busy", 32'(busy), 32'd0);
    issue(MD_MTLO, 32'h5555, 32'd0);
    @(negedge clk);
    cancel = 1'b0;
    md_op  = MD_NONE;
    check("cancel hi", hi, 32'd0);
    check("cancel lo", lo, 32'd12);

    // Reset during the third busy cycle of a DIV discards the pending result.
    issue(MD_DIV, 32'd100, 32'd7);
    @(negedge clk);
    md_op = MD_NONE;
    repeat (2) @(negedge clk);
    check("pre-reset busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid reset busy", 32'(busy), 32'd0);
    check("mid reset hi", hi, 32'd0);
    check("mid reset lo", lo, 32'd0);
    repeat (12) @(negedge clk);
    check("post reset busy", 32'(busy), 32'd0);
    check("post reset hi", hi, 32'd0);
    check("post reset lo", lo, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
